// File: rtl/ta_cap_pkg.sv
// Shared types and helpers for the capture-resource arbiter (ta_cap_arb).
// Holds the FSM state encoding, parameter defaults and the round-robin pick function.
package ta_cap_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int LEN_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TRIG = 2'd1,
    S_CAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // First set request at or above ptr, wrapping modulo nreq; supports up to 8 requesters.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned nreq);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (32'(ptr) + i) % nreq;
      if (!found && (i < nreq) && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ta_cap_arb_if.sv
// Request/grant and sync-controller handshake bundle for ta_cap_arb.
// master = requesters plus sync controller; slave = the arbiter.
interface ta_cap_arb_if #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 16
);
  logic [NREQ-1:0]  req;
  logic [LEN_W-1:0] cap_len;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  done;
  logic             cap_trig;
  logic             capr_rdy;
  logic             cap_en;
  logic             busy;
  logic             err_tmo;

  modport master (
    output req, cap_len, capr_rdy,
    input  grant, done, cap_trig, cap_en, busy, err_tmo
  );

  modport slave (
    input  req, cap_len, capr_rdy,
    output grant, done, cap_trig, cap_en, busy, err_tmo
  );
endinterface

// File: rtl/ta_rr_arb.sv
// Reusable round-robin picker: combinational winner plus a registered priority pointer.
// The pointer moves just past adv_idx whenever adv is strobed.
module ta_rr_arb
  import ta_cap_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             adv,
  input  logic [IDX_W-1:0] adv_idx,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] ptr_reg;
  logic [7:0]       req_pad;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NREQ) begin : g_used
        assign req_pad[gi] = req[gi];
      end else begin : g_zero
        assign req_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign pick_idx = IDX_W'(rr_pick(req_pad, 3'(ptr_reg), NREQ));
  assign any_req  = |req;

  always_ff @(posedge clk50) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (adv) begin
      ptr_reg <= (adv_idx == IDX_W'(NREQ - 1)) ? '0 : adv_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ta_cap_arb.sv
// Capture/sync resource arbiter: round-robin grant, trigger handshake, timed capture window.
// Optional handshake timeout is enabled by defining TA_CAP_ARB_TIMEOUT_EN.
module ta_cap_arb
  import ta_cap_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int LEN_W = LEN_W_DEF,
  parameter  int TMO_W = 20,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic          clk50,
  input logic          rst,
  ta_cap_arb_if.slave  bus
);

  state_t           state_reg;
  logic [NREQ-1:0]  grant_reg;
  logic [NREQ-1:0]  done_reg;
  logic             cap_trig_reg;
  logic             cap_en_reg;
  logic [IDX_W-1:0] owner_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic [IDX_W-1:0] pick_idx;
  logic             any_req;
  logic             adv;
  logic             tmo_hit;

`ifdef TA_CAP_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

  logic [TMO_W-1:0] tmo_reg;
  logic             err_tmo_reg;

  // Fires on the edge the counter would reach all-ones, only if the awaited handshake is still missing.
  assign tmo_hit = (tmo_reg == TMO_LAST) &&
                   (((state_reg == S_TRIG) &&  bus.capr_rdy) ||
                    ((state_reg == S_DONE) && !bus.capr_rdy));

  always_ff @(posedge clk50) begin
    if (rst || !((state_reg == S_TRIG) || (state_reg == S_DONE))) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_reg + TMO_W'(1);
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      err_tmo_reg <= 1'b0;
    end else begin
      err_tmo_reg <= tmo_hit;
    end
  end

  assign bus.err_tmo = err_tmo_reg;
`else
  assign tmo_hit     = 1'b0;
  assign bus.err_tmo = 1'b0;
`endif

  assign adv = ((state_reg == S_DONE) && bus.capr_rdy) || tmo_hit;

  ta_rr_arb #(.NREQ(NREQ)) u_rr (
    .clk50    (clk50),
    .rst      (rst),
    .req      (bus.req),
    .adv      (adv),
    .adv_idx  (owner_reg),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      grant_reg    <= '0;
      done_reg     <= '0;
      cap_trig_reg <= 1'b0;
      cap_en_reg   <= 1'b0;
      owner_reg    <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (bus.capr_rdy && any_req) begin
            grant_reg    <= NREQ'(1) << pick_idx;
            owner_reg    <= pick_idx;
            cap_trig_reg <= 1'b1;
            len_reg      <= (bus.cap_len == '0) ? LEN_W'(1) : bus.cap_len;
            state_reg    <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (!bus.capr_rdy) begin
            cap_trig_reg <= 1'b0;
            cap_en_reg   <= 1'b1;
            cnt_reg      <= len_reg - LEN_W'(1);
            state_reg    <= S_CAP;
          end else if (tmo_hit) begin
            cap_trig_reg <= 1'b0;
            grant_reg    <= '0;
            state_reg    <= S_IDLE;
          end
        end
        S_CAP: begin
          if (cnt_reg == '0) begin
            cap_en_reg <= 1'b0;
            state_reg  <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg - LEN_W'(1);
          end
        end
        S_DONE: begin
          // capr_rdy high again means the controller's memory reset has finished.
          if (bus.capr_rdy) begin
            done_reg  <= NREQ'(1) << owner_reg;
            grant_reg <= '0;
            state_reg <= S_IDLE;
          end else if (tmo_hit) begin
            grant_reg <= '0;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.done     = done_reg;
  assign bus.cap_trig = cap_trig_reg;
  assign bus.cap_en   = cap_en_reg;
  assign bus.busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ta_cap_arb.sv
// Self-checking bench for ta_cap_arb: randomized transactions against a round-robin reference model.
// Timeout scenario is exercised when TA_CAP_ARB_TIMEOUT_EN is defined.
module tb_ta_cap_arb;

  localparam int NREQ  = 4;
  localparam int LEN_W = 16;
  localparam int TMO_W = 6;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk50 = ~clk50;

  ta_cap_arb_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

  ta_cap_arb #(.NREQ(NREQ), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  typedef struct {
    logic [3:0] grant;
    logic [3:0] done;
    logic [3:0] grant_end;
    int         wait_cycles;
    int         trig_cycles;
    int         en_cycles;
    bit         en_follow;
    bit         early_done;
    bit         err_seen;
    bit         timeout;
  } obs_t;

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  // Reference arbitration rule: first set request at or above the pointer, modulo NREQ.
  function automatic int ref_winner(input logic [3:0] rq, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (rq[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = 4'd0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Plays the sync controller for one transaction and records what the DUT did; ends in the done cycle.
  task automatic run_txn(input int fall_dly, input int rise_dly, input bit chg_len, output obs_t o);
    int n;
    o = '{default: 0};
    n = 0;
    while (bus.cap_trig !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    o.wait_cycles = n;
    if (bus.cap_trig !== 1'b1) begin
      o.timeout = 1'b1;
      return;
    end
    o.grant = bus.grant;
    o.trig_cycles = 1;
    for (int i = 0; i < fall_dly; i++) begin
      tick();
      if (bus.cap_trig === 1'b1) o.trig_cycles++;
      if (bus.err_tmo !== 1'b0) o.err_seen = 1'b1;
    end
    bus.capr_rdy = 1'b0;
    n = 0;
    while (bus.cap_trig === 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus.cap_trig === 1'b1) o.trig_cycles++;
    end
    o.en_follow = (bus.cap_en === 1'b1);
    n = 0;
    while (bus.cap_en === 1'b1 && n < 70000) begin
      o.en_cycles++;
      if (chg_len && o.en_cycles == 2) bus.cap_len = 16'($urandom_range(1, 3));
      if (bus.done !== 4'd0) o.early_done = 1'b1;
      if (bus.err_tmo !== 1'b0) o.err_seen = 1'b1;
      tick();
      n++;
    end
    if (bus.cap_en === 1'b1) o.timeout = 1'b1;
    for (int i = 0; i < rise_dly; i++) begin
      if (bus.done !== 4'd0) o.early_done = 1'b1;
      tick();
    end
    bus.capr_rdy = 1'b1;
    tick();
    o.done = bus.done;
    o.grant_end = bus.grant;
    $display("txn grant=%b trig=%0d en=%0d done=%b wait=%0d", o.grant, o.trig_cycles,
             o.en_cycles, o.done, o.wait_cycles);
  endtask

  task automatic test_reset();
    bus.req = 4'd0;
    bus.cap_len = 16'd0;
    bus.capr_rdy = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.grant !== 4'd0) begin errors++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    checks++;
    if (bus.done !== 4'd0) begin errors++; $display("FAIL reset_done: got %b want 0000", bus.done); end
    checks++;
    if ({bus.cap_trig, bus.cap_en, bus.busy, bus.err_tmo} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: trig/en/busy/err got %b want 0000",
               {bus.cap_trig, bus.cap_en, bus.busy, bus.err_tmo});
    end
    rst = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_basic();
    obs_t o;
    bus.req = 4'b0001;
    bus.cap_len = 16'd5;
    run_txn(2, 20, 1'b0, o);
    checks++;
    if (o.timeout || o.grant !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b want 0001", o.grant); end
    checks++;
    if (o.trig_cycles !== 3) begin errors++; $display("FAIL basic_trig_len: got %0d want 3", o.trig_cycles); end
    checks++;
    if (!o.en_follow) begin errors++; $display("FAIL basic_en_follow: cap_en got 0 want 1 after capr_rdy fall"); end
    checks++;
    if (o.en_cycles !== 5) begin errors++; $display("FAIL basic_en_len: got %0d want 5", o.en_cycles); end
    checks++;
    if (o.early_done || o.done !== 4'b0001) begin
      errors++;
      $display("FAIL basic_done: got %b early=%0d want 0001", o.done, o.early_done);
    end
    checks++;
    if (o.grant_end !== 4'd0) begin errors++; $display("FAIL basic_grant_clear: got %b want 0000", o.grant_end); end
    exp_ptr = 1;
    bus.req = 4'd0;
    tick();
    checks++;
    if (bus.done !== 4'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b want 0000 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    obs_t o;
    int w;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ptr = 0;
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      bus.cap_len = 16'($urandom_range(1, 6));
      w = ref_winner(bus.req, exp_ptr);
      run_txn($urandom_range(0, 3), $urandom_range(1, 5), 1'b0, o);
      checks++;
      if (o.timeout || o.grant !== onehot(w)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b", t, o.grant, onehot(w));
      end
      checks++;
      if (o.done !== onehot(w)) begin errors++; $display("FAIL rr_done[%0d]: got %b want %b", t, o.done, onehot(w)); end
      if (t > 0) begin
        checks++;
        if (o.wait_cycles !== 1) begin
          errors++;
          $display("FAIL rr_gap[%0d]: got %0d idle cycles want 1", t, o.wait_cycles);
        end
      end
      exp_ptr = (w + 1) % NREQ;
    end
    bus.req = 4'd0;
    tick();
  endtask

  task automatic test_random();
    obs_t o;
    int w;
    int len;
    for (int t = 0; t < 12; t++) begin
      bus.req = 4'($urandom_range(1, 15));
      len = $urandom_range(0, 12);
      bus.cap_len = 16'(len);
      w = ref_winner(bus.req, exp_ptr);
      run_txn($urandom_range(0, 4), $urandom_range(0, 6), 1'b0, o);
      checks++;
      if (o.timeout || o.grant !== onehot(w)) begin
        errors++;
        $display("FAIL rand_grant[%0d]: req=%b got %b want %b", t, bus.req, o.grant, onehot(w));
      end
      checks++;
      if (o.en_cycles !== ((len == 0) ? 1 : len)) begin
        errors++;
        $display("FAIL rand_en_len[%0d]: got %0d want %0d", t, o.en_cycles, (len == 0) ? 1 : len);
      end
      checks++;
      if (o.early_done || o.done !== onehot(w)) begin
        errors++;
        $display("FAIL rand_done[%0d]: got %b early=%0d want %b", t, o.done, o.early_done, onehot(w));
      end
      checks++;
      if (o.err_seen) begin errors++; $display("FAIL rand_err_tmo[%0d]: got 1 want 0", t); end
      exp_ptr = (w + 1) % NREQ;
      bus.req = 4'd0;
    end
    tick();
  endtask

  task automatic test_len_bounds();
    obs_t o;
    int w;
    logic [15:0] lens [3];
    int          want [3];
    lens[0] = 16'd0;     want[0] = 1;
    lens[1] = 16'hFFFF;  want[1] = 65535;
    lens[2] = 16'd6;     want[2] = 6;
    for (int t = 0; t < 3; t++) begin
      bus.req = 4'b0100;
      bus.cap_len = lens[t];
      w = ref_winner(bus.req, exp_ptr);
      run_txn(1, 3, (t == 2), o);
      checks++;
      if (o.timeout || o.en_cycles !== want[t]) begin
        errors++;
        $display("FAIL len_bound[%0d]: cap_en cycles got %0d want %0d", t, o.en_cycles, want[t]);
      end
      checks++;
      if (o.done !== onehot(w)) begin errors++; $display("FAIL len_done[%0d]: got %b want %b", t, o.done, onehot(w)); end
      exp_ptr = (w + 1) % NREQ;
      bus.req = 4'd0;
    end
    tick();
  endtask

  task automatic test_rdy_low();
    obs_t o;
    bit seen;
    bus.capr_rdy = 1'b0;
    bus.req = 4'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ptr = 0;
    bus.req = 4'b0010;
    bus.cap_len = 16'd3;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.cap_trig !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 4'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rdy_low_idle: activity seen got 1 want 0"); end
    bus.capr_rdy = 1'b1;
    tick();
    checks++;
    if (bus.grant !== 4'b0010 || bus.cap_trig !== 1'b1) begin
      errors++;
      $display("FAIL rdy_low_grant: grant=%b trig=%b want 0010 1", bus.grant, bus.cap_trig);
    end
    run_txn(2, 4, 1'b0, o);
    checks++;
    if (o.done !== 4'b0010 || o.en_cycles !== 3) begin
      errors++;
      $display("FAIL rdy_low_txn: done=%b en=%0d want 0010 3", o.done, o.en_cycles);
    end
    exp_ptr = 2;
    bus.req = 4'd0;
    tick();
  endtask

  task automatic test_mid_reset();
    obs_t o;
    int n;
    bus.req = 4'b0100;
    bus.cap_len = 16'd20;
    n = 0;
    while (bus.cap_trig !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    bus.capr_rdy = 1'b0;
    n = 0;
    while (bus.cap_en !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (bus.cap_en !== 1'b1) begin errors++; $display("FAIL mid_rst_setup: cap_en got %b want 1", bus.cap_en); end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.grant, bus.done, bus.cap_trig, bus.cap_en, bus.busy} !== 11'd0) begin
      errors++;
      $display("FAIL mid_rst_outputs: grant=%b done=%b trig=%b en=%b busy=%b want all 0",
               bus.grant, bus.done, bus.cap_trig, bus.cap_en, bus.busy);
    end
    rst = 1'b0;
    exp_ptr = 0;
    bus.capr_rdy = 1'b1;
    bus.req = 4'b1010;
    bus.cap_len = 16'd2;
    run_txn(1, 2, 1'b0, o);
    checks++;
    if (o.timeout || o.grant !== onehot(ref_winner(4'b1010, exp_ptr))) begin
      errors++;
      $display("FAIL mid_rst_ptr: got %b want %b", o.grant, onehot(ref_winner(4'b1010, exp_ptr)));
    end
    checks++;
    if (o.early_done || o.done !== 4'b0010) begin
      errors++;
      $display("FAIL mid_rst_done: got %b early=%0d want 0010", o.done, o.early_done);
    end
    exp_ptr = 2;
    bus.req = 4'd0;
    tick();
  endtask

`ifdef TA_CAP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    int n;
    int hi;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.capr_rdy = 1'b1;
    bus.req = 4'b0001;
    bus.cap_len = 16'd4;
    n = 0;
    while (bus.cap_trig !== 1'b1 && n < 50) begin tick(); n++; end
    hi = 0;
    while (bus.cap_trig === 1'b1 && hi < 200) begin hi++; tick(); end
    bus.req = 4'd0;
    checks++;
    if (hi !== 63) begin errors++; $display("FAIL tmo_trig_len: got %0d want 63", hi); end
    checks++;
    if (bus.err_tmo !== 1'b1 || bus.grant !== 4'd0 || bus.done !== 4'd0) begin
      errors++;
      $display("FAIL tmo_pulse: err=%b grant=%b done=%b want 1 0000 0000", bus.err_tmo, bus.grant, bus.done);
    end
    tick();
    checks++;
    if (bus.err_tmo !== 1'b0 || bus.done !== 4'd0) begin
      errors++;
      $display("FAIL tmo_after: err=%b done=%b want 0 0000", bus.err_tmo, bus.done);
    end
    exp_ptr = 1;
    bus.req = 4'b0001;
    run_txn(2, 5, 1'b0, o);
    checks++;
    if (o.timeout || o.done !== 4'b0001 || o.en_cycles !== 4) begin
      errors++;
      $display("FAIL tmo_recover: done=%b en=%0d want 0001 4", o.done, o.en_cycles);
    end
    bus.req = 4'd0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_random();
    test_len_bounds();
    test_rdy_low();
    test_mid_reset();
`ifdef TA_CAP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
